c17_resp_misr: RTL and testbench

//  Response compactor for c17 BIST; sits directly downstream of c17 and consumes its outputs.

---
 rtl/c17_resp_misr.sv | 101 ++++++++++
 tb/tb_c17_resp_misr.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/c17_resp_misr.sv
// Response compactor for c17 BIST: folds each accepted {N23,N22} beat into a
// Galois MISR and compares the final signature against a golden value.
module c17_resp_misr #(
    parameter int                MISR_W = 16,
    parameter int                RESP_W = 2,
    parameter logic [MISR_W-1:0] POLY   = 16'h1021,
    parameter logic [MISR_W-1:0] SEED   = 16'hFFFF,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_pat,
    input  logic [MISR_W-1:0] golden,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  pat_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  num_pat_q;
    logic [MISR_W-1:0] golden_q;

    // One MISR step: shift, conditional feedback, then fold in the response bits.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                    input logic [RESP_W-1:0] r);
        logic [MISR_W-1:0] fb;
        fb = s[MISR_W-1] ? POLY : '0;
        return (s << 1) ^ fb ^ {{(MISR_W-RESP_W){1'b0}}, r};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            num_pat_q  <= '0;
            golden_q   <= '0;
            signature  <= SEED;
            pat_count  <= '0;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_pat_q <= num_pat;
                        golden_q  <= golden;
                        signature <= SEED;
                        pat_count <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        if (num_pat == '0) begin
                            state      <= CHECK;
                            resp_ready <= 1'b0;
                        end else begin
                            state      <= RUN;
                            resp_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        signature <= misr_next(signature, resp);
                        pat_count <= pat_count + 1'b1;
                        // Final beat: drop ready on the same edge so nothing more is taken.
                        if (pat_count == num_pat_q - 1'b1) begin
                            state      <= CHECK;
                            resp_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    pass  <= (signature == golden_q);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state      <= IDLE;
                    resp_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_resp_misr.sv
// Directed bench for c17_resp_misr with hand-computed MISR signatures.
module tb_c17_resp_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_pat;
    logic [15:0] golden;
    logic        resp_valid;
    logic [1:0]  resp;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [7:0]  pat_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    c17_resp_misr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_pat    (num_pat),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pat_count  (pat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] np, input logic [15:0] g);
        start   = 1'b1;
        num_pat = np;
        golden  = g;
        cyc();
        start   = 1'b0;
        num_pat = 8'hAA;
        golden  = 16'h5555;
    endtask

    task automatic beat(input logic v, input logic [1:0] r);
        resp_valid = v;
        resp       = r;
        cyc();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sig"},   32'(signature), 32'hFFFF);
        chk({tag, "_cnt"},   32'(pat_count), 32'h0);
        chk({tag, "_flags"}, 32'({resp_ready, busy, done, pass}), 32'h0);
    endtask

    // Two-beat run 01,10 -> EFDE then CF9F; done two clocks after the last beat.
    task automatic run2(input string tag, input logic [15:0] g, input logic exp_pass);
        pulse_start(8'd2, g);
        chk({tag, "_armed"}, 32'({resp_ready, busy, done, pass}), 32'b1100);
        beat(1'b1, 2'b01);
        chk({tag, "_sig1"}, 32'(signature), 32'hEFDE);
        chk({tag, "_cnt1"}, 32'(pat_count), 32'd1);
        beat(1'b1, 2'b10);
        chk({tag, "_sig2"}, 32'(signature), 32'hCF9F);
        chk({tag, "_chk_state"}, 32'({resp_ready, busy, done}), 32'b010);
        beat(1'b0, 2'b00);
        chk({tag, "_done"}, 32'({busy, done}), 32'b01);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_sigf"}, 32'(signature), 32'hCF9F);
        chk({tag, "_cntf"}, 32'(pat_count), 32'd2);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 20) begin
            cyc();
            k++;
        end
        chk({tag, "_timeout"}, 32'(done), 32'h1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        num_pat    = '0;
        golden     = '0;
        resp_valid = 1'b0;
        resp       = '0;
        cyc();

        // Reset state, and beats ignored while idle
        do_reset();
        check_idle("rst");
        beat(1'b1, 2'b11);
        beat(1'b1, 2'b01);
        check_idle("idle_ign");
        resp_valid = 1'b0;

        // Matching golden
        run2("t2", 16'hCF9F, 1'b1);
        cyc();
        cyc();
        chk("t2_hold", 32'({done, pass, signature}), {14'h0, 2'b11, 16'hCF9F});

        // Mismatching golden, re-armed from DONE
        pulse_start(8'd2, 16'hCF9E);
        chk("t3_rearm", 32'({done, pass}), 32'b00);
        chk("t3_seed", 32'(signature), 32'hFFFF);
        beat(1'b1, 2'b01);
        beat(1'b1, 2'b10);
        beat(1'b0, 2'b00);
        chk("t3_done", 32'({done, pass}), 32'b10);
        chk("t3_sig", 32'(signature), 32'hCF9F);

        // Zero-pattern run: no beats, straight to CHECK
        resp_valid = 1'b1;
        resp       = 2'b11;
        pulse_start(8'd0, 16'hFFFF);
        chk("t4_check", 32'({resp_ready, busy, done}), 32'b010);
        cyc();
        chk("t4_done", 32'({resp_ready, busy, done, pass}), 32'b0011);
        chk("t4_sig", 32'(signature), 32'hFFFF);
        chk("t4_cnt", 32'(pat_count), 32'h0);
        resp_valid = 1'b0;

        // Gapped valid with a mid-run start re-pulse that must be ignored
        pulse_start(8'd3, 16'h8F1C);
        beat(1'b1, 2'b01);
        start   = 1'b1;
        num_pat = 8'd1;
        golden  = 16'hFFFF;
        beat(1'b0, 2'b11);
        start = 1'b0;
        chk("t5_gap_cnt", 32'(pat_count), 32'd1);
        chk("t5_gap_sig", 32'(signature), 32'hEFDE);
        chk("t5_gap_rdy", 32'({resp_ready, busy}), 32'b11);
        beat(1'b0, 2'b10);
        beat(1'b1, 2'b10);
        chk("t5_sig2", 32'(signature), 32'hCF9F);
        beat(1'b1, 2'b11);
        chk("t5_sig3", 32'(signature), 32'h8F1C);
        chk("t5_rdy_low", 32'(resp_ready), 32'h0);
        beat(1'b1, 2'b01);
        chk("t5_no_extra", 32'({pat_count, signature}), {8'h0, 8'd3, 16'h8F1C});
        resp_valid = 1'b0;
        wait_done("t5");
        chk("t5_pass", 32'(pass), 32'h1);

        // Reset mid-run aborts; a fresh run still passes
        pulse_start(8'd2, 16'hCF9F);
        beat(1'b1, 2'b01);
        resp_valid = 1'b0;
        do_reset();
        check_idle("t6_rst");
        cyc();
        check_idle("t6_stay");
        run2("t6", 16'hCF9F, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
